axi_write_arbiter: RTL and testbench

- Sequences the AXI write path (AW -> W -> B) of the interconnect.
- Arbitrates AW requests from two masters (M0, M1) round-robin and decodes the granted address to S0, S1 or the default slave.
- Holds the grant for the whole transaction, gating AW/W handshakes to the selected slave until the matching B handshake completes.
- Its one-hot slave_sel and grant outputs steer the W/B datapath muxes.

---
 rtl/axi_write_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter
// Sequences one AXI write transaction at a time (AW -> W -> B) for two masters.
// AW requests are arbitrated round-robin, and the winning address is decoded to
// S0, S1 or the default slave (SD). The grant is held until the B handshake
// completes. While it is held, only the selected slave and the granted master
// see AW/W handshake signals.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   AWVALID_Mx/AWADDR_Mx/AWLEN_Mx master AW requests (x = 0, 1)
//   AWREADY_Sy                   slave AW ready (y = 0, 1, D)
//   AWREADY_Mx, AWVALID_Sy       gated AW handshake signals
//   WVALID_M, WLAST_M, WREADY_Sy W channel of the granted master / slaves
//   WREADY_M, WVALID_Sy          gated W handshake signals
//   BVALID_Sy, BREADY_M          B channel used to detect completion
//   grant                        one-hot {M1,M0}; steers the W/B muxes
//   slave_sel                    one-hot {S0,S1,SD}; steers the W/B muxes
//   busy                         transaction in flight
//   wlast_err                    one-cycle pulse, the cycle after a W beat
//                                whose WLAST disagrees with the beat count

module axi_write_arbiter #(
    parameter logic [31:0] S0_BASE     = 32'h0000_0000,
    parameter logic [31:0] S1_BASE     = 32'h0001_0000,
    parameter int          REGION_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AWVALID_M0,
    input  logic        AWVALID_M1,
    input  logic [31:0] AWADDR_M0,
    input  logic [31:0] AWADDR_M1,
    input  logic [3:0]  AWLEN_M0,
    input  logic [3:0]  AWLEN_M1,
    input  logic        AWREADY_S0,
    input  logic        AWREADY_S1,
    input  logic        AWREADY_SD,
    output logic        AWREADY_M0,
    output logic        AWREADY_M1,
    output logic        AWVALID_S0,
    output logic        AWVALID_S1,
    output logic        AWVALID_SD,
    input  logic        WVALID_M,
    input  logic        WLAST_M,
    input  logic        WREADY_S0,
    input  logic        WREADY_S1,
    input  logic        WREADY_SD,
    output logic        WREADY_M,
    output logic        WVALID_S0,
    output logic        WVALID_S1,
    output logic        WVALID_SD,
    input  logic        BVALID_S0,
    input  logic        BVALID_S1,
    input  logic        BVALID_SD,
    input  logic        BREADY_M,
    output logic [1:0]  grant,
    output logic [2:0]  slave_sel,
    output logic        busy,
    output logic        wlast_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;     // 0: M0 wins a tie, 1: M1 wins a tie
    logic        err_q, err_d;

    logic [2:0]  aw_valid_s, w_valid_s;
    logic        winner_m1;
    logic [31:0] win_addr;
    logic [3:0]  win_len;
    logic        aw_valid_g, aw_ready_sel, w_ready_sel, b_valid_sel;

    // XOR then shift compares only the region bits of the address.
    function automatic logic region_hit(input logic [31:0] addr, input logic [31:0] base);
        return ((addr ^ base) >> REGION_BITS) == 32'd0;
    endfunction

    function automatic logic [2:0] decode(input logic [31:0] addr);
        if (region_hit(addr, S0_BASE))      return 3'b100;
        else if (region_hit(addr, S1_BASE)) return 3'b010;
        else                                return 3'b001;
    endfunction

    // The pointer's master wins if it requests; otherwise the other master wins.
    assign winner_m1 = ptr_q ? AWVALID_M1 : ~AWVALID_M0;
    assign win_addr  = winner_m1 ? AWADDR_M1 : AWADDR_M0;
    assign win_len   = winner_m1 ? AWLEN_M1  : AWLEN_M0;

    // Signals of the granted master and the selected slave.
    assign aw_valid_g   = grant_q[1] ? AWVALID_M1 : AWVALID_M0;
    assign aw_ready_sel = |(sel_q & {AWREADY_S0, AWREADY_S1, AWREADY_SD});
    assign w_ready_sel  = |(sel_q & {WREADY_S0, WREADY_S1, WREADY_SD});
    assign b_valid_sel  = |(sel_q & {BVALID_S0, BVALID_S1, BVALID_SD});

    // NOTE: state uses non-blocking assignments so that every register samples
    // the values from before the edge, whatever the order of the statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            sel_q   <= 3'b000;
            len_q   <= 4'd0;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal gets a default at the top. Without it, a path that
    // does not assign the signal would infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        err_d      = 1'b0;
        aw_valid_s = 3'b000;
        w_valid_s  = 3'b000;
        AWREADY_M0 = 1'b0;
        AWREADY_M1 = 1'b0;
        WREADY_M   = 1'b0;

        case (state_q)
            IDLE: begin
                if (AWVALID_M0 || AWVALID_M1) begin
                    grant_d = winner_m1 ? 2'b10 : 2'b01;
                    sel_d   = decode(win_addr);
                    len_d   = win_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                aw_valid_s = sel_q & {3{aw_valid_g}};
                AWREADY_M0 = grant_q[0] & aw_ready_sel;
                AWREADY_M1 = grant_q[1] & aw_ready_sel;
                // If the master drops AWVALID without a handshake, stay in ADDR.
                if (aw_valid_g && aw_ready_sel) begin
                    cnt_d   = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                w_valid_s = sel_q & {3{WVALID_M}};
                WREADY_M  = w_ready_sel;
                if (WVALID_M && w_ready_sel) begin
                    // The beat count ends the burst. WLAST only reports an error.
                    cnt_d = cnt_q + 4'd1;
                    err_d = WLAST_M != (cnt_q == len_q);
                    if (cnt_q == len_q) state_d = RESP;
                end
            end
            RESP: begin
                if (b_valid_sel && BREADY_M) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    sel_d   = 3'b000;
                    ptr_d   = grant_q[0];   // the master that just finished loses the next tie
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign AWVALID_S0 = aw_valid_s[2];
    assign AWVALID_S1 = aw_valid_s[1];
    assign AWVALID_SD = aw_valid_s[0];
    assign WVALID_S0  = w_valid_s[2];
    assign WVALID_S1  = w_valid_s[1];
    assign WVALID_SD  = w_valid_s[0];
    assign grant      = grant_q;
    assign slave_sel  = sel_q;
    assign busy       = (state_q != IDLE);
    assign wlast_err  = err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter. It applies a table of per-cycle
// vectors, runs directed multi-cycle sequences, and then runs randomized
// traffic. Every cycle is checked against a transaction-level reference model.

module tb_axi_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  awv;            // {M1,M0}
    logic [31:0] addr [2];
    logic [3:0]  len  [2];
    logic [2:0]  awr, wr, bv;    // {S0,S1,SD}
    logic        wv, wl, br;

    logic AWREADY_M0, AWREADY_M1, AWVALID_S0, AWVALID_S1, AWVALID_SD;
    logic WREADY_M, WVALID_S0, WVALID_S1, WVALID_SD;
    logic [1:0] grant;
    logic [2:0] slave_sel;
    logic busy, wlast_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] obs;

    always #5 clk = ~clk;

    axi_write_arbiter dut (
        .clk(clk), .rst(rst),
        .AWVALID_M0(awv[0]), .AWVALID_M1(awv[1]),
        .AWADDR_M0(addr[0]), .AWADDR_M1(addr[1]),
        .AWLEN_M0(len[0]), .AWLEN_M1(len[1]),
        .AWREADY_S0(awr[2]), .AWREADY_S1(awr[1]), .AWREADY_SD(awr[0]),
        .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1),
        .AWVALID_S0(AWVALID_S0), .AWVALID_S1(AWVALID_S1), .AWVALID_SD(AWVALID_SD),
        .WVALID_M(wv), .WLAST_M(wl),
        .WREADY_S0(wr[2]), .WREADY_S1(wr[1]), .WREADY_SD(wr[0]),
        .WREADY_M(WREADY_M),
        .WVALID_S0(WVALID_S0), .WVALID_S1(WVALID_S1), .WVALID_SD(WVALID_SD),
        .BVALID_S0(bv[2]), .BVALID_S1(bv[1]), .BVALID_SD(bv[0]),
        .BREADY_M(br),
        .grant(grant), .slave_sel(slave_sel), .busy(busy), .wlast_err(wlast_err)
    );

    // Observed vector: {grant[1:0], slave_sel[2:0], busy, AWREADY_M1, AWREADY_M0,
    //                   AWVALID_S0/S1/SD, WREADY_M, WVALID_S0/S1/SD, wlast_err}
    function automatic logic [15:0] pack_dut();
        return {grant, slave_sel, busy, AWREADY_M1, AWREADY_M0,
                AWVALID_S0, AWVALID_S1, AWVALID_SD, WREADY_M,
                WVALID_S0, WVALID_S1, WVALID_SD, wlast_err};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int m_active, m_mst, m_slv, m_aw_done, m_done, m_total, m_prio;
    bit m_err;

    // Slave index from the address region: 0 = S0, 1 = S1, 2 = default.
    function automatic int region_of(input logic [31:0] a);
        if ((a >> 16) == 32'd0) return 0;
        if ((a >> 16) == 32'd1) return 1;
        return 2;
    endfunction

    function automatic logic [2:0] onehot(input int s);
        return (s == 0) ? 3'b100 : (s == 1) ? 3'b010 : 3'b001;
    endfunction

    task automatic model_reset();
        m_active = 0; m_mst = 0; m_slv = 0; m_aw_done = 0;
        m_done = 0; m_total = 0; m_prio = 0; m_err = 1'b0;
    endtask

    function automatic logic [15:0] model_out();
        logic [15:0] e;
        logic [2:0]  s;
        e = 16'h0000;
        if (m_active != 0) begin
            s = onehot(m_slv);
            e[15:14] = (m_mst == 1) ? 2'b10 : 2'b01;
            e[13:11] = s;
            e[10]    = 1'b1;
            if (m_aw_done == 0) begin
                e[8 + m_mst] = |(awr & s);
                if (awv[m_mst]) e[7:5] = s;
            end else if (m_done < m_total) begin
                e[4] = |(wr & s);
                if (wv) e[3:1] = s;
            end
        end
        e[0] = m_err;
        return e;
    endfunction

    task automatic model_step();
        logic [2:0] s;
        s = onehot(m_slv);
        m_err = 1'b0;
        if (m_active == 0) begin
            if (awv != 2'b00) begin
                if (m_prio == 0) m_mst = awv[0] ? 0 : 1;
                else             m_mst = awv[1] ? 1 : 0;
                m_slv     = region_of(addr[m_mst]);
                m_total   = int'(len[m_mst]) + 1;
                m_active  = 1;
                m_aw_done = 0;
                m_done    = 0;
            end
        end else if (m_aw_done == 0) begin
            if (awv[m_mst] && |(awr & s)) begin
                m_aw_done = 1;
                m_done    = 0;
            end
        end else if (m_done < m_total) begin
            if (wv && |(wr & s)) begin
                m_err  = (wl != ((m_done + 1) == m_total));
                m_done = m_done + 1;
            end
        end else if (|(bv & s) && br) begin
            m_active = 0;
            m_prio   = 1 - m_mst;
        end
    endtask

    // ---------------- cycle helpers ----------------
    // Called at posedge+1 with inputs already driven. Samples the DUT at the
    // negedge, then advances the model at the next posedge.
    task automatic cycle(input bit use_tbl, input logic [15:0] tbl_exp, input string name);
        logic [15:0] e;
        e = model_out();
        @(negedge clk);
        obs = pack_dut();
        check(name, obs, use_tbl ? tbl_exp : e);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        awv = 2'b00; addr[0] = 32'h0; addr[1] = 32'h0; len[0] = 4'd0; len[1] = 4'd0;
        awr = 3'b000; wr = 3'b000; bv = 3'b000; wv = 1'b0; wl = 1'b0; br = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check(name, pack_dut(), 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            case ($urandom_range(0, 3))
                0:       addr[i] = {16'h0000, 16'($urandom)};
                1:       addr[i] = {16'h0001, 16'($urandom)};
                2:       addr[i] = {16'h0002, 16'($urandom)};
                default: addr[i] = $urandom;
            endcase
            len[i] = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        end
        awv = 2'($urandom);
        awr = 3'($urandom);
        wr  = 3'($urandom);
        bv  = 3'($urandom);
        wv  = 1'($urandom);
        wl  = 1'($urandom);
        br  = 1'($urandom);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [1:0]  awv;
        logic [2:0]  awr;
        logic        wv;
        logic        wl;
        logic [2:0]  wr;
        logic [2:0]  bv;
        logic        br;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, errs;
        logic [1:0] exp_g;

        // M0 writes 0x10 with len 0 to S0. The S1 BVALID is ignored; S0 completes.
        // After that the pointer is M1, so on a tie M1 wins.
        tbl[0] = '{2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'h0000};
        tbl[1] = '{2'b01, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'h0000};
        tbl[2] = '{2'b01, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'h6580};
        tbl[3] = '{2'b00, 3'b000, 1'b1, 1'b1, 3'b100, 3'b000, 1'b0, 16'h6418};
        tbl[4] = '{2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 16'h6400};
        tbl[5] = '{2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 16'h6400};
        tbl[6] = '{2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'h0000};
        tbl[7] = '{2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 16'hA480};

        rst = 1'b1;
        clear_inputs();
        #2;
        check("reset_state", pack_dut(), 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        addr[0] = 32'h0000_0010; addr[1] = 32'h0000_0010;
        for (int i = 0; i < 8; i++) begin
            awv = tbl[i].awv; awr = tbl[i].awr; wv = tbl[i].wv; wl = tbl[i].wl;
            wr = tbl[i].wr; bv = tbl[i].bv; br = tbl[i].br;
            cycle(1'b1, tbl[i].exp, $sformatf("tbl_row%0d", i));
        end

        // Continuous contention: grants alternate M0/M1 with one IDLE cycle between them.
        clear_inputs();
        do_reset("reset_contention");
        awv = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20;
        awr = 3'b100; wv = 1'b1; wl = 1'b1; wr = 3'b100; bv = 3'b100; br = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 16'h0, "contention_model");
            exp_g = (k % 4 == 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("contention_grant%0d", k), 16'(obs[15:14]), 16'(exp_g));
        end

        // M1: len 3 to S1, with WREADY toggling and WLAST on the 4th beat.
        clear_inputs();
        do_reset("reset_m1");
        awv = 2'b10; addr[1] = 32'h0001_0004; len[1] = 4'd3; awr = 3'b010;
        cycle(1'b0, 16'h0, "m1_idle");
        cycle(1'b0, 16'h0, "m1_addr");
        check("m1_grant_sel", 16'(obs[15:11]), 16'({2'b10, 3'b010}));
        awv = 2'b00; wv = 1'b1;
        hs = 0; errs = 0;
        for (int i = 0; i < 30 && hs < 4; i++) begin
            wr = (i % 2 == 0) ? 3'b010 : 3'b000;
            wl = (hs == 3);
            cycle(1'b0, 16'h0, "m1_data");
            if (obs[4]) hs++;
            if (obs[0]) errs++;
        end
        check("m1_beats", 16'(hs), 16'd4);
        wr = 3'b010; wl = 1'b0;
        cycle(1'b0, 16'h0, "m1_resp");
        if (obs[0]) errs++;
        check("m1_resp_state", 16'({obs[10], obs[4]}), 16'b10);
        check("m1_no_wlast_err", 16'(errs), 16'd0);
        wv = 1'b0; bv = 3'b010; br = 1'b1;
        cycle(1'b0, 16'h0, "m1_b");
        bv = 3'b000;
        cycle(1'b0, 16'h0, "m1_done");
        check("m1_busy_dropped", 16'(obs[10]), 16'd0);

        // Default slave: only the SD valids are driven; BVALID_S0 is ignored.
        clear_inputs();
        awv = 2'b01; addr[0] = 32'h0002_0000; awr = 3'b001;
        cycle(1'b0, 16'h0, "sd_idle");
        cycle(1'b0, 16'h0, "sd_addr");
        check("sd_awvalid", 16'({obs[13:11], obs[7:5]}), 16'({3'b001, 3'b001}));
        awv = 2'b00; wv = 1'b1; wl = 1'b1; wr = 3'b001;
        cycle(1'b0, 16'h0, "sd_data");
        check("sd_wvalid", 16'(obs[3:1]), 16'b001);
        wv = 1'b0; bv = 3'b100; br = 1'b1;
        cycle(1'b0, 16'h0, "sd_resp_wrong_b");
        bv = 3'b000;
        cycle(1'b0, 16'h0, "sd_resp_wait");
        check("sd_bvalid_s0_ignored", 16'(obs[10]), 16'd1);
        bv = 3'b001;
        cycle(1'b0, 16'h0, "sd_resp_b");
        bv = 3'b000;
        cycle(1'b0, 16'h0, "sd_done");
        check("sd_busy_dropped", 16'(obs[10]), 16'd0);

        // Early WLAST: len 1 with WLAST on the first beat gives exactly one error pulse.
        clear_inputs();
        awv = 2'b01; addr[0] = 32'h10; len[0] = 4'd1; awr = 3'b100;
        cycle(1'b0, 16'h0, "err_idle");
        cycle(1'b0, 16'h0, "err_addr");
        awv = 2'b00; wv = 1'b1; wl = 1'b1; wr = 3'b100;
        hs = 0; errs = 0;
        for (int i = 0; i < 10 && hs < 2; i++) begin
            cycle(1'b0, 16'h0, "err_data");
            if (obs[4]) hs++;
            if (obs[0]) errs++;
        end
        wv = 1'b0; wl = 1'b0;
        cycle(1'b0, 16'h0, "err_resp");
        if (obs[0]) errs++;
        check("err_beats", 16'(hs), 16'd2);
        check("err_pulse_count", 16'(errs), 16'd1);
        check("err_resp_state", 16'({obs[10], obs[4]}), 16'b10);
        bv = 3'b100; br = 1'b1;
        cycle(1'b0, 16'h0, "err_b");
        clear_inputs();
        cycle(1'b0, 16'h0, "err_done");

        // Reset in the middle of a burst. First move the pointer to M1, then
        // check that reset brings back M0 priority.
        clear_inputs();
        do_reset("reset_pre_mid");
        awv = 2'b01; addr[0] = 32'h10; awr = 3'b100; wv = 1'b1; wl = 1'b1;
        wr = 3'b100; bv = 3'b100; br = 1'b1;
        cycle(1'b0, 16'h0, "rm_idle");
        cycle(1'b0, 16'h0, "rm_addr");
        awv = 2'b00;
        cycle(1'b0, 16'h0, "rm_data");
        cycle(1'b0, 16'h0, "rm_resp");
        awv = 2'b01; len[0] = 4'd3; wl = 1'b0; bv = 3'b000;
        cycle(1'b0, 16'h0, "rm_idle2");
        cycle(1'b0, 16'h0, "rm_addr2");
        awv = 2'b00;
        cycle(1'b0, 16'h0, "rm_beat1");
        cycle(1'b0, 16'h0, "rm_beat2");
        do_reset("rst_mid_outputs");
        clear_inputs();
        awv = 2'b11; addr[0] = 32'h10; addr[1] = 32'h10;
        cycle(1'b0, 16'h0, "rm_after_idle");
        cycle(1'b0, 16'h0, "rm_after_addr");
        check("rst_mid_m0_priority", 16'(obs[15:14]), 16'b01);

        // Randomized traffic checked against the model.
        clear_inputs();
        do_reset("reset_random");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("reset_random_mid");
            end
            randomize_inputs();
            cycle(1'b0, 16'h0, "random");
        end

        clear_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
